// File: rtl/vexriscv_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vexriscv_bus_pkg
//  Purpose  : Shared types and helpers for the VexRiscv dBus crossbar:
//             controller states, access-size codes, lane-mask and
//             alignment helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package vexriscv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    DECERR   = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Byte-lane enables for an access of the given size at the given byte offset.
  function automatic logic [3:0] size_to_mask(input logic [1:0] size,
                                              input logic [1:0] addr_lo);
    case (size)
      SIZE_B:  return 4'b0001 << addr_lo;
      SIZE_H:  return 4'b0011 << addr_lo;
      default: return 4'b1111;
    endcase
  endfunction

  // Accesses must be naturally aligned; size code 3 has no legal encoding.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return addr_lo[0];
      SIZE_W:  return |addr_lo;
      default: return 1'b1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vexriscv_dbus_xbar_if.sv
`default_nettype none
// ============================================================================
//  Module   : vexriscv_dbus_xbar_if
//  Purpose  : Bundle of the core-side dBus and the shared slave-side bus of
//             the dBus crossbar, with views for the crossbar, the core
//             (master) and the targets (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface vexriscv_dbus_xbar_if #(
  parameter int N_SLAVES = 4
);
  // core side
  logic                  m_cmd_valid;
  logic                  m_cmd_ready;
  logic                  m_cmd_wr;
  logic [31:0]           m_cmd_address;
  logic [31:0]           m_cmd_data;
  logic [1:0]            m_cmd_size;
  logic                  m_rsp_ready;
  logic                  m_rsp_error;
  logic [31:0]           m_rsp_data;
  // target side
  logic [N_SLAVES-1:0]   s_cmd_valid;
  logic [N_SLAVES-1:0]   s_cmd_ready;
  logic                  s_cmd_wr;
  logic [31:0]           s_cmd_address;
  logic [31:0]           s_cmd_data;
  logic [3:0]            s_cmd_mask;
  logic [N_SLAVES-1:0]   s_rsp_valid;
  logic [N_SLAVES-1:0]   s_rsp_error;
  logic [N_SLAVES*32-1:0] s_rsp_data;
  // error reporting
  logic                  bus_err;
  logic [31:0]           bus_err_addr;

  modport xbar (
    input  m_cmd_valid, m_cmd_wr, m_cmd_address, m_cmd_data, m_cmd_size,
    output m_cmd_ready, m_rsp_ready, m_rsp_error, m_rsp_data,
    output s_cmd_valid, s_cmd_wr, s_cmd_address, s_cmd_data, s_cmd_mask,
    input  s_cmd_ready, s_rsp_valid, s_rsp_error, s_rsp_data,
    output bus_err, bus_err_addr
  );

  modport master (
    output m_cmd_valid, m_cmd_wr, m_cmd_address, m_cmd_data, m_cmd_size,
    input  m_cmd_ready, m_rsp_ready, m_rsp_error, m_rsp_data,
    input  bus_err, bus_err_addr
  );

  modport slave (
    input  s_cmd_valid, s_cmd_wr, s_cmd_address, s_cmd_data, s_cmd_mask,
    output s_cmd_ready, s_rsp_valid, s_rsp_error, s_rsp_data
  );

endinterface
`default_nettype wire

// File: rtl/dbus_addr_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : dbus_addr_decoder
//  Purpose  : Combinational base/mask address decoder. Produces a one-hot
//             select, a hit flag and the binary index of the selected slave;
//             the lowest-indexed matching slave wins.
//  Revision : 1.0 - initial release
// ============================================================================
module dbus_addr_decoder #(
  parameter int                     N_SLAVES   = 4,
  parameter int                     IDX_W      = 2,
  parameter logic [N_SLAVES*32-1:0] SLAVE_BASE = '0,
  parameter logic [N_SLAVES*32-1:0] SLAVE_MASK = '0
) (
  input  logic [31:0]         i_addr,
  output logic [N_SLAVES-1:0] o_sel,
  output logic                o_hit,
  output logic [IDX_W-1:0]    o_idx
);

  logic [N_SLAVES-1:0] w_match;

  for (genvar g = 0; g < N_SLAVES; g++) begin : g_match
    assign w_match[g] = ((i_addr & SLAVE_MASK[g*32 +: 32]) ==
                         (SLAVE_BASE[g*32 +: 32] & SLAVE_MASK[g*32 +: 32]));
  end

  // Priority select: scanning downwards lets the lowest match overwrite.
  always_comb begin
    o_sel = '0;
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        o_sel    = '0;
        o_sel[i] = 1'b1;
        o_hit    = 1'b1;
        o_idx    = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vexriscv_dbus_xbar.sv
`default_nettype none
// ============================================================================
//  Module   : vexriscv_dbus_xbar
//  Purpose  : Single-outstanding dBus crossbar from the VexRiscv core to
//             N address-decoded targets, with byte-lane masks, slave
//             back-pressure, multi-cycle reads, timeout and error responses.
//  Revision : 1.0 - initial release
// ============================================================================
module vexriscv_dbus_xbar
  import vexriscv_bus_pkg::*;
#(
  parameter int                     N_SLAVES       = 4,
  // index 0 at the LSBs: 0=0x1000_0000, 1=0x1000_1000, 2=0x1000_2000, 3=RAM
  parameter logic [N_SLAVES*32-1:0] SLAVE_BASE     = {32'h0000_0000, 32'h1000_2000,
                                                      32'h1000_1000, 32'h1000_0000},
  parameter logic [N_SLAVES*32-1:0] SLAVE_MASK     = {32'hFFFF_0000, 32'hFFFF_F000,
                                                      32'hFFFF_F000, 32'hFFFF_F000},
  parameter int                     TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  vexriscv_dbus_xbar_if.xbar  dbus
);

  localparam int          IDX_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e              r_state;
  logic [N_SLAVES-1:0] r_sel;
  logic [IDX_W-1:0]    r_idx;
  logic                r_wr;
  logic [31:0]         r_addr;
  logic [31:0]         r_data;
  logic [3:0]          r_mask;
  logic [15:0]         r_cnt;
  logic                r_rsp_ready;
  logic                r_rsp_error;
  logic [31:0]         r_rsp_data;
  logic                r_bus_err;
  logic [31:0]         r_bus_err_addr;

  logic [N_SLAVES-1:0] w_sel;
  logic                w_hit;
  logic [IDX_W-1:0]    w_idx;
  logic                w_cmd_err;
  logic                w_slv_ready;
  logic                w_slv_rsp;
  logic                w_tmo;

  dbus_addr_decoder #(
    .N_SLAVES   (N_SLAVES),
    .IDX_W      (IDX_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decoder (
    .i_addr (dbus.m_cmd_address),
    .o_sel  (w_sel),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );

  assign w_cmd_err   = !w_hit || is_misaligned(dbus.m_cmd_size, dbus.m_cmd_address[1:0]);
  assign w_slv_ready = |(dbus.s_cmd_ready & r_sel);
  assign w_slv_rsp   = |(dbus.s_rsp_valid & r_sel);
  // true on the TIMEOUT_CYCLES-th cycle spent in ISSUE or WAIT_RSP
  assign w_tmo       = (r_cnt == TMO_LAST);

  // The core handshake is combinational off the selected slave so both
  // handshakes complete in the same cycle; DECERR completes it unconditionally.
  assign dbus.m_cmd_ready   = ((r_state == ISSUE) && w_slv_ready) || (r_state == DECERR);
  assign dbus.s_cmd_valid   = (r_state == ISSUE) ? r_sel : '0;
  assign dbus.s_cmd_wr      = r_wr;
  assign dbus.s_cmd_address = r_addr;
  assign dbus.s_cmd_data    = r_data;
  assign dbus.s_cmd_mask    = r_mask;
  assign dbus.m_rsp_ready   = r_rsp_ready;
  assign dbus.m_rsp_error   = r_rsp_error;
  assign dbus.m_rsp_data    = r_rsp_data;
  assign dbus.bus_err       = r_bus_err;
  assign dbus.bus_err_addr  = r_bus_err_addr;

  // Transaction controller; response and error flags are one-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_sel          <= '0;
      r_idx          <= '0;
      r_wr           <= 1'b0;
      r_addr         <= '0;
      r_data         <= '0;
      r_mask         <= '0;
      r_cnt          <= '0;
      r_rsp_ready    <= 1'b0;
      r_rsp_error    <= 1'b0;
      r_rsp_data     <= '0;
      r_bus_err      <= 1'b0;
      r_bus_err_addr <= '0;
    end else begin
      r_rsp_ready <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_data  <= '0;
      r_bus_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (dbus.m_cmd_valid) begin
            r_wr   <= dbus.m_cmd_wr;
            r_addr <= dbus.m_cmd_address;
            r_data <= dbus.m_cmd_data;
            r_mask <= size_to_mask(dbus.m_cmd_size, dbus.m_cmd_address[1:0]);
            r_sel  <= w_sel;
            r_idx  <= w_idx;
            r_cnt  <= '0;
            if (w_cmd_err) begin
              r_state        <= DECERR;
              r_bus_err      <= 1'b1;
              r_bus_err_addr <= dbus.m_cmd_address;
            end else begin
              r_state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // a slave accept on the timeout cycle takes precedence
          if (w_slv_ready) begin
            r_cnt   <= '0;
            r_state <= r_wr ? IDLE : WAIT_RSP;
          end else if (w_tmo) begin
            r_state        <= DECERR;
            r_bus_err      <= 1'b1;
            r_bus_err_addr <= r_addr;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        WAIT_RSP: begin
          // a response on the timeout cycle takes precedence
          if (w_slv_rsp) begin
            r_rsp_ready <= 1'b1;
            r_rsp_error <= dbus.s_rsp_error[r_idx];
            r_rsp_data  <= dbus.s_rsp_data[32*r_idx +: 32];
            r_state     <= IDLE;
          end else if (w_tmo) begin
            r_rsp_ready    <= 1'b1;
            r_rsp_error    <= 1'b1;
            r_bus_err      <= 1'b1;
            r_bus_err_addr <= r_addr;
            r_state        <= IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        DECERR: begin
          // errored writes are dropped silently; reads get an error response
          r_rsp_ready <= !r_wr;
          r_rsp_error <= !r_wr;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
